// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: tracks the fetch PC, runs the instruction-memory
// req/ready handshake and presents PC+4 / instruction (or a NOP bubble)
// to the IF/ID pipeline register.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,             // asynchronous, active-low
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_out,
   output logic [31:0] Instruction_out,
   output logic        if_valid
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FULL  = 2'd2,
      S_DROP  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   drop_addr_q, drop_addr_d;
   logic [XLEN-1:0]   buf_instr_q, buf_instr_d;
   logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
   logic [XLEN-1:0]   pc_inc;

   // State and datapath registers; reset abandons any in-flight request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         drop_addr_q <= '0;
         buf_instr_q <= '0;
         buf_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

   // Next-state logic; a taken branch overrides freeze in every state.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      pc_inc      = pc_q + PC_STEP;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            if (branch_taken) pc_d = branch_addr;
         end
         S_FETCH: begin
            if (branch_taken) begin
               pc_d = branch_addr;
               if (!imem_ready) begin
                  // Request already on the bus must complete before redirecting.
                  drop_addr_d = pc_q;
                  state_d     = S_DROP;
               end
            end else if (imem_ready) begin
               buf_instr_d = imem_rdata;
               buf_pc_d    = pc_inc;
               pc_d        = pc_inc;
               state_d     = S_FULL;
            end
         end
         S_FULL: begin
            if (branch_taken) begin
               pc_d    = branch_addr;
               state_d = S_FETCH;
            end else if (!freeze) begin
               // Held word is consumed; refill in the same cycle if memory answers.
               if (imem_ready) begin
                  buf_instr_d = imem_rdata;
                  buf_pc_d    = pc_inc;
                  pc_d        = pc_inc;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_DROP: begin
            if (branch_taken) pc_d = branch_addr;
            if (imem_ready) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Memory request: held stable in FETCH/DROP, gated by freeze/branch in FULL.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_q;
      case (state_q)
         S_FETCH: imem_req = 1'b1;
         S_FULL:  imem_req = ~freeze & ~branch_taken;
         S_DROP: begin
            imem_req  = 1'b1;
            imem_addr = drop_addr_q;
         end
         default: imem_req = 1'b0;
      endcase
   end

   // IF/ID payload: real instruction only in FULL outside a branch cycle.
   always_comb begin
      if_valid        = (state_q == S_FULL) & ~branch_taken;
      Instruction_out = if_valid ? buf_instr_q : NOP_INSTR;
      PC_out          = if_valid ? buf_pc_q : '0;
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized freeze/branch
// traffic against a variable-latency memory, with a program-order scoreboard.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] PC_out;
   logic [31:0] Instruction_out;
   logic        if_valid;

   logic        mem_rdy = 1'b0;
   logic [31:0] mem_data = 32'h0;
   logic        pulse_rdy;

   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_pc;
   logic [31:0] w_instr;
   logic        w_valid;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_consumed = 0;

   int          lat_mode;
   int          fixed_wait;
   bit          busy = 1'b0;
   logic [31:0] cur_addr = 32'h0;
   int          wait_left = 0;

   logic [31:0] exp_q[$];
   logic [31:0] prog_next;

   assign imem_ready = mem_rdy | pulse_rdy;
   assign imem_rdata = pulse_rdy ? 32'hDEAD_BEEF : mem_data;

   if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_out(PC_out),
      .Instruction_out(Instruction_out), .if_valid(if_valid)
   );

   // Second instance: zero-wait memory, reset PC at the top of the address space.
   if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_w (
      .clk(clk), .rst(rst), .freeze(1'b0), .branch_taken(1'b0),
      .branch_addr(32'h0), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ready(w_req), .imem_rdata(w_addr ^ 32'hA000_0000), .PC_out(w_pc),
      .Instruction_out(w_instr), .if_valid(w_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA000_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   // Expected program order: consecutive words from the last restart point.
   task automatic sb_refill();
      while (exp_q.size() < 8) begin
         exp_q.push_back(prog_next);
         prog_next = prog_next + 32'd4;
      end
   endtask

   task automatic sb_restart(input logic [31:0] a);
      exp_q.delete();
      prog_next = a;
      sb_refill();
   endtask

   task automatic tick_pos();
      @(posedge clk);
      #1;
      sb_refill();
   endtask

   task automatic tick_neg();
      @(negedge clk);
      #1;
      sb_refill();
   endtask

   task automatic wait_req(input logic [31:0] a, input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick_neg();
         if (imem_req && imem_addr == a) begin
            found = 1'b1;
            return;
         end
      end
   endtask

   // Memory model: latency chosen per request; also checks that an
   // outstanding request keeps its address until it is answered.
   always @(negedge clk) begin
      if (!rst) begin
         busy    = 1'b0;
         mem_rdy = 1'b0;
      end else if (imem_req) begin
         if (busy) begin
            chk("req_addr_hold", imem_addr, cur_addr);
         end else begin
            busy     = 1'b1;
            cur_addr = imem_addr;
            if (lat_mode == 0)      wait_left = 0;
            else if (lat_mode == 1) wait_left = fixed_wait;
            else                    wait_left = int'($urandom_range(0, 3));
         end
         if (wait_left == 0) begin
            mem_rdy  = 1'b1;
            mem_data = mem_word(cur_addr);
            busy     = 1'b0;
         end else begin
            mem_rdy = 1'b0;
            wait_left--;
         end
      end else begin
         if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_held: request for %h dropped before ready (t=%0t)", cur_addr, $time);
         end
         busy    = 1'b0;
         mem_rdy = 1'b0;
      end
   end

   // Monitor: pops the scoreboard whenever the IF/ID register captures a real instruction.
   always @(negedge clk) begin : mon
      logic [31:0] a;
      if (rst) begin
         if (if_valid) begin
            if (!freeze) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_empty: unexpected instruction pc_out=%h (t=%0t)", PC_out, $time);
               end else begin
                  a = exp_q.pop_front();
                  chk("pc_out", PC_out, a + 32'd4);
                  chk("instr_out", Instruction_out, mem_word(a));
                  n_consumed++;
               end
            end
         end else begin
            chk("bubble_instr", Instruction_out, NOP);
            chk("bubble_pc", PC_out, 32'h0);
         end
         if (branch_taken) chk1("branch_bubble", if_valid, 1'b0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          found;
      logic [31:0] ba;
      rst          = 1'b0;
      freeze       = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = 32'h0;
      pulse_rdy    = 1'b0;
      lat_mode     = 0;
      fixed_wait   = 3;
      prog_next    = 32'h0;

      // Reset values
      repeat (3) tick_pos();
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", if_valid, 1'b0);
      chk("rst_instr", Instruction_out, NOP);
      chk("rst_pc", PC_out, 32'h0);
      chk1("rst_w_req", w_req, 1'b0);
      sb_restart(32'h0);
      tick_neg();
      rst = 1'b1;

      // Zero-wait: first valid two cycles after release
      tick_neg();
      chk1("c1_valid", if_valid, 1'b0);
      chk1("c1_req", imem_req, 1'b1);
      chk("c1_addr", imem_addr, 32'h0);
      tick_neg();
      chk1("c2_valid", if_valid, 1'b1);
      chk("c2_addr", imem_addr, 32'h4);
      chk1("wrap_valid", w_valid, 1'b1);
      chk("wrap_pc", w_pc, 32'h0);
      chk("wrap_instr", w_instr, mem_word(32'hFFFF_FFFC));
      chk("wrap_next_addr", w_addr, 32'h0);

      // Freeze for three cycles while holding the word from address 8
      wait_req(32'h8, 20, found);
      chk1("found_req8", found, 1'b1);
      tick_pos();
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick_neg();
         chk1("frz_valid", if_valid, 1'b1);
         chk("frz_pc", PC_out, 32'd12);
         chk("frz_instr", Instruction_out, mem_word(32'h8));
         chk1("frz_req", imem_req, 1'b0);
      end
      tick_pos();
      freeze = 1'b0;
      tick_neg();
      chk1("unfrz_req", imem_req, 1'b1);
      chk("unfrz_addr", imem_addr, 32'd12);

      // Three wait states: request held four cycles, bubbles meanwhile
      lat_mode = 1;
      for (int i = 0; i < 4; i++) begin
         tick_neg();
         chk1("w3_req", imem_req, 1'b1);
         chk("w3_addr", imem_addr, 32'd16);
         if (i > 0) begin
            chk1("w3_valid", if_valid, 1'b0);
            chk("w3_nop", Instruction_out, NOP);
         end
      end
      tick_neg();
      chk1("w3_arrive_valid", if_valid, 1'b1);
      chk("w3_arrive_pc", PC_out, 32'd20);
      chk("w3_next_addr", imem_addr, 32'd20);

      // Asynchronous reset in the middle of a request; late ready during IDLE
      tick_pos();
      #2;
      rst = 1'b0;
      #1;
      chk1("async_rst_req", imem_req, 1'b0);
      chk1("async_rst_valid", if_valid, 1'b0);
      tick_neg();
      tick_pos();
      #2;
      rst       = 1'b1;
      pulse_rdy = 1'b1;
      sb_restart(32'h0);
      tick_pos();
      pulse_rdy = 1'b0;
      tick_neg();
      chk1("post_rst_req", imem_req, 1'b1);
      chk("post_rst_addr", imem_addr, 32'h0);
      chk1("post_rst_valid", if_valid, 1'b0);

      // Branch while fetching address 8 with waits still pending
      wait_req(32'h8, 60, found);
      chk1("found_req8b", found, 1'b1);
      tick_pos();
      branch_taken = 1'b1;
      branch_addr  = 32'h100;
      sb_restart(32'h100);
      tick_pos();
      branch_taken = 1'b0;
      wait_req(32'h100, 20, found);
      chk1("found_req100", found, 1'b1);

      // Branch and freeze together in FULL
      lat_mode = 0;
      tick_pos();
      freeze = 1'b1;
      found  = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick_neg();
         found = if_valid;
      end
      chk1("found_full", found, 1'b1);
      tick_pos();
      branch_taken = 1'b1;
      branch_addr  = 32'h200;
      sb_restart(32'h200);
      tick_neg();
      chk1("bf_valid", if_valid, 1'b0);
      chk("bf_instr", Instruction_out, NOP);
      chk("bf_pc", PC_out, 32'h0);
      chk1("bf_req", imem_req, 1'b0);
      tick_pos();
      branch_taken = 1'b0;
      freeze       = 1'b0;
      tick_neg();
      chk1("bf_next_req", imem_req, 1'b1);
      chk("bf_next_addr", imem_addr, 32'h200);

      // Randomized traffic
      lat_mode = 2;
      for (int n = 0; n < 3000; n++) begin
         tick_pos();
         freeze = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 2))
               0:       ba = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
               1:       ba = 32'($urandom_range(0, 255)) << 2;
               default: ba = $urandom() & 32'hFFFF_FFFC;
            endcase
            branch_taken = 1'b1;
            branch_addr  = ba;
            sb_restart(ba);
         end else begin
            branch_taken = 1'b0;
         end
      end
      tick_pos();
      branch_taken = 1'b0;
      freeze       = 1'b0;
      repeat (10) tick_pos();
      chk1("progress", n_consumed > 200, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
